// File: rtl/alu32_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu32_seq
// Purpose  : Sequenced command front end for an external combinational alu32.
//            Takes one ALU or load-immediate command at a time over a
//            valid/ready handshake. It reads operands from an internal
//            register file, drives them to alu32 as registered outputs, then
//            writes the result and flags back. Each command takes three cycles:
//            IDLE (accept) -> EXEC (alu32 settles, write-back) -> DONE (pulse).
//
// Ports    : clk, reset_n         clock, async active-low reset
//            cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//            cmd_ld, cmd_op       load-immediate select, ALU op code
//            cmd_rd/rs1/rs2       destination / operand register indices
//            cmd_imm              immediate for loads
//            cmd_cmp              compare-only (only with ALU32_SEQ_CMP_EN)
//            done                 one-cycle pulse when a command retires
//            alu_a/alu_b/alu_op   registered operands/op to alu32
//            alu_result, alu_c/n/z/v  result and flags returned by alu32
//            flags                retained {c,n,z,v}
//            dbg_addr/dbg_data    combinational register-file read port
//
// Config   : ALU32_SEQ_CMP_EN - adds cmd_cmp. An ALU command with cmd_cmp=1
//            updates flags only and does not write the register file.
// Revision : 1.0 - initial release
// ============================================================================
module alu32_seq #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [31:0]   cmd_imm,
`ifdef ALU32_SEQ_CMP_EN
  input  logic          cmd_cmp,
`endif
  output logic          done,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_result,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic [3:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam int C_NREG = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done_q, done_d;
  logic            ld_q, ld_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [31:0]     imm_q, imm_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [3:0]      flags_q, flags_d;
  logic [31:0]     rf_q [C_NREG];
  logic [31:0]     rf_d [C_NREG];
`ifdef ALU32_SEQ_CMP_EN
  logic            cmp_q, cmp_d;
`endif

  // Register-file write enable for an ALU command in EXEC. Compare-only
  // commands keep the destination untouched.
  logic            alu_wr;

  always_comb begin
`ifdef ALU32_SEQ_CMP_EN
    alu_wr = !cmp_q;
`else
    alu_wr = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    ld_d        = ld_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    flags_d     = flags_q;
    rf_d        = rf_q;
`ifdef ALU32_SEQ_CMP_EN
    cmp_d       = cmp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Operands are sampled here, so rd == rs1 == rs2 sees pre-write values.
          ld_d        = cmd_ld;
          rd_d        = cmd_rd;
          imm_d       = cmd_imm;
          alu_a_d     = rf_q[cmd_rs1];
          alu_b_d     = rf_q[cmd_rs2];
          alu_op_d    = cmd_op;
`ifdef ALU32_SEQ_CMP_EN
          cmp_d       = cmd_cmp;
`endif
          cmd_ready_d = 1'b0;
          state_d     = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (ld_q) begin
          rf_d[rd_q] = imm_q;
        end else begin
          flags_d = {alu_c, alu_n, alu_z, alu_v};
          if (alu_wr) begin
            rf_d[rd_q] = alu_result;
          end
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any command in flight: nothing above is committed once
  // reset_n falls, so no write-back and no done pulse can follow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      ld_q        <= 1'b0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      flags_q     <= '0;
`ifdef ALU32_SEQ_CMP_EN
      cmp_q       <= 1'b0;
`endif
      for (int i = 0; i < C_NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      flags_q     <= flags_d;
`ifdef ALU32_SEQ_CMP_EN
      cmp_q       <= cmp_d;
`endif
      for (int i = 0; i < C_NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign flags     = flags_q;
  // Reads the flops, so a same-cycle write is not visible until after its edge.
  assign dbg_data  = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu32_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_seq
// Purpose  : Directed self-checking bench for alu32_seq with a behavioural
//            alu32 attached (op codes: 000 ~a, 001 ~b, 010 and, 011 or,
//            100 xor, 101 xnor, 110 add, 111 sub; c = carry / no-borrow).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_seq;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_ld;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic        cmd_cmp;
  logic        done;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_c, alu_n, alu_z, alu_v;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int done_cyc;
  int d1;

  alu32_seq #(.AW(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ld     (cmd_ld),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
`ifdef ALU32_SEQ_CMP_EN
    .cmd_cmp    (cmd_cmp),
`endif
    .done       (done),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural alu32.
  always_comb begin
    logic [32:0] s;
    s     = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      3'b000: alu_result = ~alu_a;
      3'b001: alu_result = ~alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~(alu_a ^ alu_b);
      3'b110: begin
        s          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = s[31:0];
        alu_c      = s[32];
        alu_v      = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      default: begin
        s          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = s[31:0];
        alu_c      = s[32];
        alu_v      = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
      end
    endcase
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic set_cmd(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [31:0] imm, input logic cmp);
    cmd_ld  = ld;
    cmd_op  = op;
    cmd_rd  = rd;
    cmd_rs1 = rs1;
    cmd_rs2 = rs2;
    cmd_imm = imm;
    cmd_cmp = cmp;
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic start(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [31:0] imm, input logic cmp);
    int n;
    @(negedge clk);
    set_cmd(ld, op, rd, rs1, rs2, imm, cmp);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 6);
    chk("done_seen", {31'd0, done}, 32'd1);
    done_cyc = cyc;
    chk("done_latency", done_cyc - acc_cyc, 32'd1);
  endtask

  task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [31:0] imm, input logic cmp);
    start(ld, op, rd, rs1, rs2, imm, cmp);
    cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    dbg_addr  = '0;
    set_cmd(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    reset_n = 1'b1;
    chk_rf("rst_rf3", 3'd3, 32'd0);

    // ---- load r1=5 then r2=3 with valid held throughout ----
    start(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd5, 1'b0);
    set_cmd(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd3, 1'b0);
    @(negedge clk);
    chk("ld_ready_lo1", {31'd0, cmd_ready}, 32'd0);
    chk("ld_done_lo", {31'd0, done}, 32'd0);
    wait_done();
    chk("ld_ready_lo2", {31'd0, cmd_ready}, 32'd0);
    d1 = done_cyc;
    @(negedge clk);
    chk("ld_ready_hi", {31'd0, cmd_ready}, 32'd1);
    chk("ld_done_once", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    chk("ld_accept2", {31'd0, cmd_ready}, 32'd0);
    wait_done();
    chk("ld_done_spacing", done_cyc - d1, 32'd3);
    chk_rf("ld_r1", 3'd1, 32'd5);
    chk_rf("ld_r2", 3'd2, 32'd3);

    // ---- sub r3 = r1 - r2 ----
    run_cmd(1'b0, 3'b111, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0);
    chk("sub_flags", {28'd0, flags}, 32'b1000);
    chk_rf("sub_r3", 3'd3, 32'd2);
    chk("sub_hold_a", alu_a, 32'd5);
    chk("sub_hold_b", alu_b, 32'd3);
    chk("sub_hold_op", {29'd0, alu_op}, 32'd7);

    // ---- signed overflow: r4 = 0x7FFFFFFF + 1 ----
    run_cmd(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b0);
    run_cmd(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd1, 1'b0);
    run_cmd(1'b0, 3'b110, 3'd4, 3'd1, 3'd2, 32'd0, 1'b0);
    chk("ovf_flags", {28'd0, flags}, 32'b0101);
    chk_rf("ovf_r4", 3'd4, 32'h8000_0000);

    // ---- logic ops and aliasing ----
    run_cmd(1'b0, 3'b100, 3'd5, 3'd1, 3'd1, 32'd0, 1'b0);
    chk("xor_flags", {28'd0, flags}, 32'b0010);
    chk_rf("xor_r5", 3'd5, 32'd0);
    run_cmd(1'b1, 3'd0, 3'd7, 3'd1, 3'd2, 32'h0000_00AA, 1'b0);
    chk("ld_keeps_flags", {28'd0, flags}, 32'b0010);
    run_cmd(1'b0, 3'b010, 3'd1, 3'd1, 3'd1, 32'd0, 1'b0);
    chk("and_flags", {28'd0, flags}, 32'b0000);
    chk_rf("and_r1", 3'd1, 32'h7FFF_FFFF);

    // ---- held valid: second command reads the first one's result ----
    start(1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 32'h0000_1234, 1'b0);
    set_cmd(1'b0, 3'b110, 3'd6, 3'd5, 3'd5, 32'd0, 1'b0);
    wait_done();
    @(negedge clk);
    chk("held_ready_hi", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    chk("held_opnd_a", alu_a, 32'h0000_1234);
    wait_done();
    chk_rf("held_r6", 3'd6, 32'h0000_2468);

    // ---- reset during EXEC of add to r6 ----
    run_cmd(1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 32'h0000_0055, 1'b0);
    chk_rf("pre_rst_r6", 3'd6, 32'h0000_0055);
    start(1'b0, 3'b110, 3'd6, 3'd1, 3'd2, 32'd0, 1'b0);
    cmd_valid = 1'b0;
    #2;
    reset_n  = 1'b0;
    dbg_addr = 3'd6;
    #1;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_r6", dbg_data, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    chk("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk_rf("abort_r6_after", 3'd6, 32'd0);

    // ---- compare-only sub r7 = r1 - r2 with r1 = r2 = 9 ----
    run_cmd(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd9, 1'b0);
    run_cmd(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd9, 1'b0);
    run_cmd(1'b1, 3'd0, 3'd7, 3'd0, 3'd0, 32'h0000_00AA, 1'b0);
    run_cmd(1'b0, 3'b111, 3'd7, 3'd1, 3'd2, 32'd0, 1'b1);
    chk("cmp_flags", {28'd0, flags}, 32'b1010);
`ifdef ALU32_SEQ_CMP_EN
    chk_rf("cmp_r7", 3'd7, 32'h0000_00AA);
`else
    chk_rf("cmp_r7", 3'd7, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
